// File: rtl/load_arbiter_if.sv
// Bundle of player inputs and load-register outputs shared between the arbiter
// and whatever drives the players' buttons.
interface load_arbiter_if;
   logic       btn_p0;
   logic       btn_p1;
   logic [3:0] data_p0;
   logic [3:0] data_p1;
   logic       sig_load;
   logic [3:0] data_load;
   logic       owner;
   logic       busy;
   logic [3:0] cnt_p0;
   logic [3:0] cnt_p1;

   modport master (
      output btn_p0, btn_p1, data_p0, data_p1,
      input  sig_load, data_load, owner, busy, cnt_p0, cnt_p1
   );

   modport slave (
      input  btn_p0, btn_p1, data_p0, data_p1,
      output sig_load, data_load, owner, busy, cnt_p0, cnt_p1
   );
endinterface

// File: rtl/load_arbiter.sv
// Two-player arbiter for a shared load register: rising button edges are
// latched as one-deep requests and granted one at a time, round-robin on ties.
module load_arbiter (
   input  logic           clk,
   input  logic           rst,
   load_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      HOLD = 2'b10
   } state_t;

   state_t     state;
   state_t     state_next;

   logic       btn_q0;
   logic       btn_q1;
   logic       pend0;
   logic       pend1;
   logic       last_grant;
   logic       owner_r;
   logic [3:0] data_load_r;
   logic [3:0] cnt0;
   logic [3:0] cnt1;

   logic       edge0;
   logic       edge1;
   logic       want0;
   logic       want1;
   logic       grant0;
   logic       grant1;
   logic       owner_btn;

   // Button history resets high so a button held through reset is not an edge.
   always_comb begin
      edge0     = bus.btn_p0 & ~btn_q0;
      edge1     = bus.btn_p1 & ~btn_q1;
      want0     = pend0 | edge0;
      want1     = pend1 | edge1;
      owner_btn = owner_r ? bus.btn_p1 : bus.btn_p0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // On a tie the player not granted last wins; a lone requester always wins.
   always_comb begin
      state_next = state;
      grant0     = 1'b0;
      grant1     = 1'b0;
      case (state)
         IDLE: begin
            if (want0 && want1) begin
               grant0 = last_grant;
               grant1 = ~last_grant;
            end else begin
               grant0 = want0;
               grant1 = want1;
            end
            if (want0 || want1) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            state_next = HOLD;
         end
         HOLD: begin
            if (!owner_btn) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q0      <= 1'b1;
         btn_q1      <= 1'b1;
         pend0       <= 1'b0;
         pend1       <= 1'b0;
         last_grant  <= 1'b1;
         owner_r     <= 1'b0;
         data_load_r <= 4'h0;
         cnt0        <= 4'h0;
         cnt1        <= 4'h0;
      end else begin
         btn_q0 <= bus.btn_p0;
         btn_q1 <= bus.btn_p1;
         pend0  <= (pend0 | edge0) & ~grant0;
         pend1  <= (pend1 | edge1) & ~grant1;
         if (grant0) begin
            data_load_r <= bus.data_p0;
            owner_r     <= 1'b0;
            last_grant  <= 1'b0;
            if (cnt0 != 4'hF) begin
               cnt0 <= cnt0 + 4'd1;
            end
         end else if (grant1) begin
            data_load_r <= bus.data_p1;
            owner_r     <= 1'b1;
            last_grant  <= 1'b1;
            if (cnt1 != 4'hF) begin
               cnt1 <= cnt1 + 4'd1;
            end
         end
      end
   end

   assign bus.sig_load  = (state == LOAD);
   assign bus.busy      = (state != IDLE);
   assign bus.data_load = data_load_r;
   assign bus.owner     = owner_r;
   assign bus.cnt_p0    = cnt0;
   assign bus.cnt_p1    = cnt1;

endmodule

// File: doc/load_arbiter.md
LOAD_ARBITER -- requirements
Module: load_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  system clock; all state updates on posedge CLK.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 btn_p0  input  1  player-0 confirm button; level, debounced, active-high.
REQ-005 btn_p1  input  1  player-1 confirm button; level, debounced, active-high.
REQ-006 data_p0  input  4  player-0 input value.
REQ-007 data_p1  input  4  player-1 input value.
REQ-008 sig_load  output  1  one-cycle load strobe to the shared load register.
REQ-009 data_load  output  4  value presented to the shared load register; valid while sig_load=1.
REQ-010 owner  output  1  index of the player most recently granted.
REQ-011 busy  output  1  high when the FSM is not in IDLE.
REQ-012 cnt_p0  output  4  number of grants to player 0; saturating.
REQ-013 cnt_p1  output  4  number of grants to player 1; saturating.

Function
REQ-014 Each button SHALL be registered (btn_q) every cycle; a request edge exists for player x when btn_px=1 and btn_qx=0 at a clock edge.
REQ-015 A request edge SHALL set a one-deep pending flag for that player; further edges while pending is set are absorbed and do not queue.
REQ-016 The FSM SHALL have exactly three states: IDLE, LOAD and HOLD; an unreachable encoding SHALL return to IDLE.
REQ-017 IDLE: if any pending flag or request edge exists at an edge, the FSM SHALL grant one player and go to LOAD at that same edge; otherwise it stays in IDLE.
REQ-018 On grant, the block SHALL register data_load <= data_px and owner <= x, set sig_load=1, clear pending_x, and increment cnt_px.
REQ-019 Request-edge latency: an edge detected at clock k in IDLE SHALL make sig_load high for the cycle between edges k and k+1.
REQ-020 LOAD SHALL last exactly one cycle; sig_load SHALL be 1 only in LOAD, and the FSM SHALL then go to HOLD.
REQ-021 HOLD SHALL persist while btn_p[owner]=1 and SHALL go to IDLE at the first edge with btn_p[owner]=0.
REQ-022 Requests from the non-owner during LOAD/HOLD SHALL be latched as pending and served from IDLE.
REQ-023 Simultaneous requests (both pending or edge in IDLE) SHALL be granted round-robin to the player not granted last; the last-grant pointer resets to 1, so player 0 wins the first tie.
REQ-024 A single requester SHALL be granted regardless of the last-grant pointer.
REQ-025 cnt_px SHALL saturate at 4'hF; no wrap to 0.
REQ-026 busy SHALL be 1 in LOAD and HOLD, and 0 in IDLE.
REQ-027 data_load and owner SHALL hold their last granted values outside LOAD.

Reset
REQ-028 When RST=1 at an edge, the block SHALL set the FSM to IDLE, sig_load=0, data_load=4'h0, owner=0, busy=0, cnt_p0=cnt_p1=4'h0, clear both pending flags, and set the last-grant pointer to 1.
REQ-029 Reset SHALL load btn_q0=btn_q1=1, so a button held through reset produces no grant until it is released and pressed again.
REQ-030 Reset asserted in LOAD or HOLD SHALL abort the grant; no sig_load pulse SHALL follow.

Verification
REQ-031 Reset, then btn_p0 pulse 0->1 with data_p0=4'hA -> sig_load=1 for exactly 1 cycle, data_load=4'hA, owner=0, cnt_p0=1.
REQ-032 Both buttons rise on the same edge after reset (data 4'h3/4'h5) -> first grant to p0 (data_load=3); after p0 releases -> second grant to p1 (data_load=5); a later tie -> p0 granted.
REQ-033 p0 held in HOLD while p1 presses and releases -> p1 is granted only after p0 releases, as one sig_load pulse; a second p1 press during HOLD adds no extra grant.
REQ-034 Hold btn_p1 across RST deassertion -> no sig_load; release then press -> one grant.
REQ-035 Make 17 p0 grants -> cnt_p0 reads 4'hF and stays at 4'hF.
REQ-036 Assert RST during HOLD with p1 pending -> all outputs at reset values and no subsequent grant without a new edge.
